// File: rtl/divider_arb_pkg.sv
// divider_arb_pkg: FSM encoding, divider width and bypass quotient shared by the arbiter.
package divider_arb_pkg;
  localparam int DIV_WIDTH = 128;
  localparam logic [DIV_WIDTH-1:0] QUOT_ONES = '1;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
endpackage

// File: rtl/divider_request_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  logic [NUM_REQ-1:0] rot;
  assign rot = NUM_REQ'({req, req} >> ptr);
  always_comb begin
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) idx = ID_W'((int'(ptr) + k) % NUM_REQ);
    any = |req;
    grant = any ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/divider_request_arbiter.sv
// divider_request_arbiter: round-robin sharing of one sequential divider between requesters.
// Optional DIV_ZERO_BYPASS_EN answers zero divisors locally without starting the divider.
import divider_arb_pkg::*;
module divider_request_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DIV_WIDTH,
  parameter int ID_W    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]           rsp_quotient,
  output logic [WIDTH-1:0]           rsp_remainder,
  output logic                       rsp_err,
  output logic                       div_start,
  output logic [WIDTH-1:0]           div_dividend,
  output logic [WIDTH-1:0]           div_divisor,
  input  logic                       div_done,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic [WIDTH-1:0]           div_remainder,
  output logic                       busy,
  output logic [ID_W-1:0]            grant_id
);
  state_t state, next;
  logic [ID_W-1:0] rr_ptr, win;
  logic [NUM_REQ-1:0] gnt;
  logic any, byp, err;
  logic [WIDTH-1:0] sel_dvd, sel_dvs;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req(req_valid), .ptr(rr_ptr), .grant(gnt), .idx(win), .any(any)
  );
  assign sel_dvd = req_dividend[int'(win)*WIDTH +: WIDTH];
  assign sel_dvs = req_divisor[int'(win)*WIDTH +: WIDTH];
`ifdef DIV_ZERO_BYPASS_EN
  assign byp = sel_dvs == '0;
`else
  assign byp = 1'b0;
`endif
  assign rsp_err = err;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = any ? (byp ? RESP : ISSUE) : IDLE;
      ISSUE:   next = WAIT;
      WAIT:    next = div_done ? RESP : WAIT;
      default: next = IDLE;
    endcase
    req_ready = state == IDLE ? gnt : '0;
    rsp_valid = state == RESP ? NUM_REQ'(1) << grant_id : '0;
    div_start = state == ISSUE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      div_dividend <= '0;
      div_divisor <= '0;
      rsp_quotient <= '0;
      rsp_remainder <= '0;
      err <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && any) begin
        grant_id <= win;
        rr_ptr <= win == ID_W'(NUM_REQ - 1) ? '0 : win + ID_W'(1);
        div_dividend <= sel_dvd;
        div_divisor <= sel_dvs;
        err <= byp;
        if (byp) begin
          rsp_quotient <= WIDTH'(QUOT_ONES);
          rsp_remainder <= sel_dvd;
        end
      end
      if (state == WAIT && div_done) begin
        rsp_quotient <= div_quotient;
        rsp_remainder <= div_remainder;
      end
    end
  end
endmodule
